// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx among NUM_REQ byte-stream requesters.
// A grant is held from the first byte until the byte flagged last has left the transmitter.

module uart_tx_arbiter_lane #(
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    sel,
    input  logic                    send,
    input  logic [PAYLOAD_BITS-1:0] data,
    input  logic                    last,
    output logic                    ready,
    output logic [PAYLOAD_BITS-1:0] data_sel,
    output logic                    last_sel
);
    assign ready    = sel & send;
    assign data_sel = sel ? data : '0;
    assign last_sel = sel & last;
endmodule

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int GAP_TIMEOUT  = 0,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            grant_valid,
    output logic [IDW-1:0]                  grant_id,
    output logic                            abort,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy
);
    localparam int GW      = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam int GAP_LIM = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;

    state_t                                  state;
    logic   [IDW-1:0]                        ptr;
    logic   [GW-1:0]                         gap_cnt;
    logic                                    last_q;
    logic   [NUM_REQ-1:0]                    sel_mask;
    logic   [NUM_REQ-1:0]                    lane_last;
    logic   [NUM_REQ-1:0][PAYLOAD_BITS-1:0]  lane_data;
    logic   [PAYLOAD_BITS-1:0]               sel_data;
    logic                                    sel_last;
    logic                                    cur_valid;
    logic                                    hs;
    logic                                    pick_found;
    logic   [IDW-1:0]                        pick_id;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign sel_mask[g] = (grant_id == IDW'(g));
        uart_tx_arbiter_lane #(.PAYLOAD_BITS(PAYLOAD_BITS)) u_lane (
            .sel      (sel_mask[g]),
            .send     (state == SEND),
            .data     (req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .last     (req_last[g]),
            .ready    (req_ready[g]),
            .data_sel (lane_data[g]),
            .last_sel (lane_last[g])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) sel_data |= lane_data[i];
    end

    assign sel_last  = |lane_last;
    assign cur_valid = |(req_valid & sel_mask);
    assign hs        = |(req_valid & req_ready);

    // Rotating search starting just after the last holder.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            automatic int idx = (int'(ptr) + k) % NUM_REQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            grant_valid  <= 1'b0;
            grant_id     <= '0;
            abort        <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            last_q       <= 1'b0;
            ptr          <= IDW'(NUM_REQ - 1);
            gap_cnt      <= '0;
        end else begin
            abort      <= 1'b0;
            uart_tx_en <= 1'b0;
            case (state)
                IDLE: if (pick_found && !uart_tx_busy) begin
                    grant_id    <= pick_id;
                    grant_valid <= 1'b1;
                    gap_cnt     <= '0;
                    state       <= SEND;
                end
                SEND: if (hs) begin
                    uart_tx_data <= sel_data;
                    last_q       <= sel_last;
                    uart_tx_en   <= 1'b1;
                    gap_cnt      <= '0;
                    state        <= ACK;
                end else if (GAP_TIMEOUT != 0 && !cur_valid) begin
                    // The idle cycle that would bring the count to GAP_TIMEOUT drops the packet.
                    if (gap_cnt == GW'(GAP_LIM)) begin
                        abort       <= 1'b1;
                        ptr         <= grant_id;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ACK: if (uart_tx_busy) state <= DONE;
                DONE: if (!uart_tx_busy) begin
                    if (last_q) begin
                        ptr         <= grant_id;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx busy/serial model.
module tb_uart_tx_arbiter;
    localparam int N = 4, PB = 8, BUSY_CYC = 20;

    logic            clk = 1'b0, resetn = 1'b0;
    logic [N-1:0]    req_valid = '0, req_last = '0;
    logic [N*PB-1:0] req_data = '0;
    logic [N-1:0]    req_ready, req_ready2;
    logic            grant_valid, grant_valid2, abort, abort2, uart_tx_en, uart_tx_en2;
    logic [1:0]      grant_id, grant_id2;
    logic [PB-1:0]   uart_tx_data, uart_tx_data2;
    logic            uart_tx_busy, force_busy = 1'b0, tx_line, abort2_seen = 1'b0;
    int              mb_cnt, n_sent = 0, passed = 0, total = 0;
    logic [9:0]      frame;
    logic [7:0]      sent_data [64];
    logic [1:0]      sent_id [64];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .GAP_TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant_valid(grant_valid), .grant_id(grant_id), .abort(abort),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy));

    uart_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(PB), .GAP_TIMEOUT(0)) dut2 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready2), .grant_valid(grant_valid2), .grant_id(grant_id2), .abort(abort2),
        .uart_tx_en(uart_tx_en2), .uart_tx_data(uart_tx_data2), .uart_tx_busy(uart_tx_busy));

    // uart_tx stand-in: start bit, 8 data bits LSB first, stop bit, 2 cycles per bit.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mb_cnt <= 0;
            frame  <= '1;
        end else if (mb_cnt != 0) begin
            mb_cnt <= mb_cnt - 1;
        end else if (uart_tx_en) begin
            mb_cnt <= BUSY_CYC;
            frame  <= {1'b1, uart_tx_data, 1'b0};
        end
    end
    assign uart_tx_busy = force_busy | (mb_cnt != 0);
    assign tx_line      = (mb_cnt != 0) ? frame[(BUSY_CYC - mb_cnt) >> 1] : 1'b1;

    always @(posedge clk) begin
        if (uart_tx_en && n_sent < 64) begin
            sent_data[n_sent] <= uart_tx_data;
            sent_id[n_sent]   <= grant_id;
            n_sent            <= n_sent + 1;
        end
        if (abort2) abort2_seen <= 1'b1;
    end

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]          = v;
        req_data[i*PB +: PB]  = d;
        req_last[i]           = l;
    endtask

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (req_ready[i]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!grant_valid && !uart_tx_busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; force_busy = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        total++;
        if ({grant_valid, abort, uart_tx_en} !== 3'b000 || grant_id !== 2'd0 || uart_tx_data !== 8'h00 || req_ready !== 4'h0)
            $display("FAIL reset_outputs: gv=%b ab=%b en=%b id=%0d data=%h rdy=%b, want all zero",
                     grant_valid, abort, uart_tx_en, grant_id, uart_tx_data, req_ready);
        else passed++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (grant_valid !== 1'b0 || req_ready !== 4'h0)
            $display("FAIL reset_idle: gv=%b rdy=%b, want 0 0000", grant_valid, req_ready);
        else passed++;
    endtask

    task automatic test_single_byte();
        int n0;
        bit ok;
        logic [9:0] line;
        n0 = n_sent;
        set_req(0, 1, 8'hA5, 1);
        @(negedge clk);
        total++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001)
            $display("FAIL single_grant: gv=%b id=%0d rdy=%b, want 1 0 0001", grant_valid, grant_id, req_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hA5)
            $display("FAIL single_strobe: en=%b data=%h, want 1 a5", uart_tx_en, uart_tx_data);
        else passed++;
        set_req(0, 0, 8'h00, 0);
        @(negedge clk);
        total++;
        if (uart_tx_en !== 1'b0 || uart_tx_busy !== 1'b1)
            $display("FAIL single_strobe_width: en=%b busy=%b, want 0 1", uart_tx_en, uart_tx_busy);
        else passed++;
        for (int b = 0; b < 10; b++) begin
            line[b] = tx_line;
            repeat (2) @(negedge clk);
        end
        total++;
        if (line !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL single_serial: frame=%b, want %b", line, {1'b1, 8'hA5, 1'b0});
        else passed++;
        wait_idle(ok);
        total++;
        if (!ok || n_sent !== n0 + 1)
            $display("FAIL single_release: idle=%b strobes=%0d, want 1 %0d", ok, n_sent - n0, 1);
        else passed++;
    endtask

    task automatic test_packet_lock();
        int n0, turn;
        bit ok, all_ok, saw2;
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        n0 = n_sent; all_ok = 1'b1; saw2 = 1'b0;
        set_req(2, 1, 8'h77, 1);
        for (int k = 0; k < 3; k++) begin
            set_req(1, 1, bytes[k], k == 2);
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (req_ready[2]) saw2 = 1'b1;
                if (req_ready[1]) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            all_ok &= ok;
            @(negedge clk);
        end
        set_req(1, 0, 8'h00, 0);
        for (int c = 0; c < 100 && !uart_tx_busy; c++) @(negedge clk);
        for (int c = 0; c < 100 && uart_tx_busy; c++) begin
            if (req_ready[2]) saw2 = 1'b1;
            @(negedge clk);
        end
        turn = 0;
        for (int c = 0; c < 20 && !req_ready[2]; c++) begin
            turn++;
            @(negedge clk);
        end
        total++;
        if (!all_ok || saw2)
            $display("FAIL lock_hold: req1_served=%b ready2_early=%b, want 1 0", all_ok, saw2);
        else passed++;
        total++;
        if (turn !== 2) $display("FAIL lock_turnaround: cycles=%0d, want 2", turn);
        else passed++;
        @(negedge clk);
        set_req(2, 0, 8'h00, 0);
        wait_idle(ok);
        total++;
        if (!ok || n_sent !== n0 + 4 || sent_data[n0] !== 8'h11 || sent_data[n0+1] !== 8'h22 ||
            sent_data[n0+2] !== 8'h33 || sent_data[n0+3] !== 8'h77 || sent_id[n0] !== 2'd1 ||
            sent_id[n0+2] !== 2'd1 || sent_id[n0+3] !== 2'd2)
            $display("FAIL lock_sequence: n=%0d data=%h %h %h %h ids=%0d %0d, want 4 11 22 33 77 ids 1 2",
                     n_sent - n0, sent_data[n0], sent_data[n0+1], sent_data[n0+2], sent_data[n0+3],
                     sent_id[n0+2], sent_id[n0+3]);
        else passed++;
    endtask

    task automatic test_round_robin();
        int n0;
        bit ok;
        do_reset();
        n0 = n_sent;
        for (int i = 0; i < N; i++) set_req(i, 1, 8'(8'hB0 + i), 1);
        for (int c = 0; c < 1500 && n_sent < n0 + 6; c++) @(negedge clk);
        req_valid = '0;
        wait_idle(ok);
        total++;
        if (!ok || n_sent !== n0 + 6) $display("FAIL rr_count: strobes=%0d, want 6", n_sent - n0);
        else passed++;
        for (int j = 0; j < 6; j++) begin
            total++;
            if (sent_id[n0+j] !== 2'(j % 4) || sent_data[n0+j] !== 8'(8'hB0 + (j % 4)))
                $display("FAIL rr_order[%0d]: id=%0d data=%h, want %0d %h", j, sent_id[n0+j],
                         sent_data[n0+j], j % 4, 8'(8'hB0 + (j % 4)));
            else passed++;
        end
    endtask

    task automatic test_busy_at_request();
        bit held, ok;
        int n0;
        n0 = n_sent; held = 1'b0;
        force_busy = 1'b1;
        set_req(2, 1, 8'h5C, 1);
        repeat (6) begin
            @(negedge clk);
            if (grant_valid) held = 1'b1;
        end
        total++;
        if (held) $display("FAIL busy_no_grant: grant seen while busy, want none");
        else passed++;
        force_busy = 1'b0;
        @(negedge clk);
        total++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2)
            $display("FAIL busy_then_grant: gv=%b id=%0d, want 1 2", grant_valid, grant_id);
        else passed++;
        wait_ready(2, ok);
        @(negedge clk);
        set_req(2, 0, 8'h00, 0);
        wait_idle(ok);
        total++;
        if (!ok || n_sent !== n0 + 1 || sent_data[n0] !== 8'h5C)
            $display("FAIL busy_byte: n=%0d data=%h, want 1 5c", n_sent - n0, sent_data[n0]);
        else passed++;
    endtask

    task automatic test_gap_timeout();
        bit ok;
        int cnt;
        set_req(3, 1, 8'h3A, 0);
        set_req(0, 1, 8'h0F, 1);
        wait_ready(3, ok);
        total++;
        if (!ok || req_ready[0] !== 1'b0)
            $display("FAIL gap_grant3: ready3=%b ready0=%b, want 1 0", ok, req_ready[0]);
        else passed++;
        @(negedge clk);
        set_req(3, 0, 8'h00, 0);
        wait_ready(3, ok);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (abort) break;
            if (req_ready[3]) cnt++;
            @(negedge clk);
        end
        total++;
        if (abort !== 1'b1 || cnt !== 16)
            $display("FAIL gap_abort_time: abort=%b send_cycles=%0d, want 1 16", abort, cnt);
        else passed++;
        total++;
        if (grant_valid !== 1'b0) $display("FAIL gap_release: gv=%b, want 0", grant_valid);
        else passed++;
        total++;
        if (grant_valid2 !== 1'b1 || grant_id2 !== 2'd3 || abort2 !== 1'b0)
            $display("FAIL gap0_hold: gv=%b id=%0d abort=%b, want 1 3 0", grant_valid2, grant_id2, abort2);
        else passed++;
        @(negedge clk);
        total++;
        if (abort !== 1'b0 || grant_valid !== 1'b1 || grant_id !== 2'd0)
            $display("FAIL gap_next: abort=%b gv=%b id=%0d, want 0 1 0", abort, grant_valid, grant_id);
        else passed++;
        wait_ready(0, ok);
        @(negedge clk);
        set_req(0, 0, 8'h00, 0);
        wait_idle(ok);
        total++;
        if (!ok || grant_valid2 !== 1'b1 || grant_id2 !== 2'd3 || abort2_seen !== 1'b0)
            $display("FAIL gap0_still_held: gv=%b id=%0d abort_seen=%b, want 1 3 0",
                     grant_valid2, grant_id2, abort2_seen);
        else passed++;
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        set_req(2, 1, 8'h44, 0);
        set_req(0, 1, 8'h55, 1);
        wait_ready(2, ok);
        total++;
        if (!ok || grant_id !== 2'd2)
            $display("FAIL mid_grant: ready2=%b id=%0d, want 1 2", ok, grant_id);
        else passed++;
        @(negedge clk);
        for (int c = 0; c < 50 && !uart_tx_busy; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if ({grant_valid, abort, uart_tx_en, grant_valid2} !== 4'b0000 || grant_id !== 2'd0 ||
            uart_tx_data !== 8'h00 || req_ready !== 4'h0 || grant_id2 !== 2'd0)
            $display("FAIL async_reset: gv=%b ab=%b en=%b id=%0d data=%h rdy=%b gv2=%b id2=%0d, want all zero",
                     grant_valid, abort, uart_tx_en, grant_id, uart_tx_data, req_ready, grant_valid2, grant_id2);
        else passed++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0 || grant_id2 !== 2'd0)
            $display("FAIL reset_first_arb: gv=%b id=%0d id2=%0d, want 1 0 0", grant_valid, grant_id, grant_id2);
        else passed++;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_packet_lock();
        test_round_robin();
        test_busy_at_request();
        test_gap_timeout();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
